ram_burst_master: RTL and testbench

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

---
 rtl/ram_burst_master.sv | 97 +++++++++
 tb/tb_ram_burst_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst master for a single-port synchronous RAM: writes or reads 1..16
// consecutive words starting at a base address, with valid/ready client ports.
module ram_burst_master (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        wr,
    input  logic [7:0]  base_addr,
    input  logic [4:0]  len,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic        ram_write_enable,
    output logic        ram_read_enable
);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_ISSUE, RD_CAP, RD_HOLD, DONE
    } state_t;

    state_t     state;
    logic [7:0] base_q;
    logic [4:0] len_q;
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic       last;

    assign cnt_nxt = cnt + 5'd1;
    assign last    = (cnt_nxt == len_q);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    len_q  <= len;
                    cnt    <= '0;
                    // Illegal lengths skip straight to DONE without touching RAM
                    if (len == 5'd0 || len > 5'd16) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        err   <= 1'b0;
                        state <= wr ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: if (wvalid) begin
                    cnt <= cnt_nxt;
                    if (last) state <= DONE;
                end
                RD_ISSUE: state <= RD_CAP;
                RD_CAP: begin
                    rdata  <= ram_data_out;
                    rvalid <= 1'b1;
                    state  <= RD_HOLD;
                end
                RD_HOLD: if (rready) begin
                    rvalid <= 1'b0;
                    cnt    <= cnt_nxt;
                    state  <= last ? DONE : RD_ISSUE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign wready = (state == WRITE);

    // Address wraps naturally in 8 bits
    assign ram_address = base_q + {3'b000, cnt};
    assign ram_data_in = wready ? wdata : 32'd0;

    // Strobes are gated by clr so the reset edge never commits a RAM access
    assign ram_write_enable = clr & wready & wvalid;
    assign ram_read_enable  = clr & (state == RD_ISSUE);

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: RAM model, burst-level reference model of the
// expected RAM traffic and read data, and a per-cycle compare process.
module tb_ram_burst_master;

    logic        clk = 1'b0;
    logic        clr, start, wr, wvalid, rready;
    logic [7:0]  base_addr;
    logic [4:0]  len;
    logic [31:0] wdata;
    logic        wready, rvalid, busy, done, err;
    logic [31:0] rdata;
    logic [7:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic        ram_write_enable, ram_read_enable;

    always #5 clk = ~clk;

    ram_burst_master dut (
        .clk(clk), .clr(clr), .start(start), .wr(wr), .base_addr(base_addr),
        .len(len), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .busy(busy),
        .done(done), .err(err), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable)
    );

    // RAM with a preload port driven by the bench
    logic [31:0] ram [256];
    logic [31:0] ram_q;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    assign ram_data_out = ram_q;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_write_enable) ram[ram_address] <= ram_data_in;
        if (ram_read_enable) ram_q <= ram[ram_address];
    end

    // Reference model state
    logic [31:0] model_mem [256];
    logic [7:0]  exp_waddr[$];
    logic [31:0] exp_wdata[$];
    logic [7:0]  exp_raddr[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] rd_log[$];
    logic [31:0] wd_q[$];
    int          wr_strobes, rd_strobes, done_cnt;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Per-cycle compare against the expected RAM traffic and read stream
    always @(negedge clk) begin
        check("enables_exclusive", {31'd0, ram_write_enable & ram_read_enable}, 32'd0);
        if (!busy || done) begin
            check("idle_wready", {31'd0, wready}, 32'd0);
            check("idle_rvalid", {31'd0, rvalid}, 32'd0);
            check("idle_wen", {31'd0, ram_write_enable}, 32'd0);
            check("idle_ren", {31'd0, ram_read_enable}, 32'd0);
        end
        if (done) done_cnt++;
        if (ram_write_enable) begin
            wr_strobes++;
            checks++;
            if (exp_waddr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", ram_address, ram_data_in);
            end else begin
                check("wr_addr", {24'd0, ram_address}, {24'd0, exp_waddr.pop_front()});
                check("wr_data", ram_data_in, exp_wdata.pop_front());
            end
        end
        if (ram_read_enable) begin
            rd_strobes++;
            checks++;
            if (exp_raddr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%h", ram_address);
            end else
                check("rd_addr", {24'd0, ram_address}, {24'd0, exp_raddr.pop_front()});
        end
        if (rvalid) begin
            checks++;
            if (exp_rdata.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid rdata=%h", rdata);
            end else begin
                check("rdata", rdata, exp_rdata[0]);
                if (rready) begin
                    rd_log.push_back(rdata);
                    void'(exp_rdata.pop_front());
                end
            end
        end
    end

    task automatic burst(input bit w, input logic [7:0] b, input logic [4:0] l,
                         input bit rnd, input int stall, input bit poke);
        bit         legal, got_done;
        int         k, t, busy_cnt, exp_busy;
        logic [7:0] a;
        legal = (l != 5'd0) && (l <= 5'd16);
        while (wd_q.size() < 17) wd_q.push_back($urandom);
        exp_waddr.delete(); exp_wdata.delete();
        exp_raddr.delete(); exp_rdata.delete(); rd_log.delete();
        if (legal) begin
            for (int i = 0; i < int'(l); i++) begin
                a = b + i[7:0];
                if (w) begin
                    exp_waddr.push_back(a);
                    exp_wdata.push_back(wd_q[i]);
                    model_mem[a] = wd_q[i];
                end else begin
                    exp_raddr.push_back(a);
                    exp_rdata.push_back(model_mem[a]);
                end
            end
        end
        @(posedge clk); #1;
        wr_strobes = 0; rd_strobes = 0; done_cnt = 0;
        start = 1'b1; wr = w; base_addr = b; len = l; wvalid = 1'b0; rready = 1'b0;
        @(posedge clk);
        k = 0; t = 0; busy_cnt = 0; got_done = 1'b0;
        while (!got_done && t < 600) begin
            #1;
            start = poke && legal && (t == 0);
            if (start) begin
                wr = !w; base_addr = 8'($urandom); len = 5'($urandom);
            end
            wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wdata  = (k < int'(l)) ? wd_q[k] : $urandom;
            rready = rnd ? 1'($urandom_range(0, 1)) : (t >= stall);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (wvalid && wready) k++;
            if (done) got_done = 1'b1;
            t++;
            @(posedge clk);
        end
        #1;
        start = 1'b0; wvalid = 1'b0; rready = 1'b0;
        @(negedge clk);
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_done", {31'd0, done}, 32'd0);
        check("err", {31'd0, err}, {31'd0, !legal});
        check("done_pulses", done_cnt, 1);
        check("wr_strobes", wr_strobes, (legal && w) ? int'(l) : 0);
        check("rd_strobes", rd_strobes, (legal && !w) ? int'(l) : 0);
        check("exp_left", exp_waddr.size() + exp_raddr.size() + exp_rdata.size(), 0);
        if (!rnd && stall == 0) begin
            exp_busy = !legal ? 1 : (w ? int'(l) + 1 : 3 * int'(l) + 1);
            check("busy_cycles", busy_cnt, exp_busy);
        end
        wd_q.delete();
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; wr = 1'b0; base_addr = '0; len = '0;
        wdata = '0; wvalid = 1'b0; rready = 1'b0;
        pre_en = 1'b1; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 256; i++) begin
            pre_addr = i[7:0];
            pre_data = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, i[7:0] + 8'h03};
            if (i == 32'h92) pre_data = 32'h46;
            if (i == 32'h93) pre_data = 32'h97;
            model_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_addr", {24'd0, ram_address}, 32'd0);
        check("rst_din", ram_data_in, 32'd0);
        @(posedge clk); #1 clr = 1'b1;

        // Directed write burst
        wd_q = '{32'h11, 32'h22, 32'h33};
        burst(1'b1, 8'h54, 5'd3, 1'b0, 0, 1'b0);
        check("w54", ram[8'h54], 32'h11);
        check("w55", ram[8'h55], 32'h22);
        check("w56", ram[8'h56], 32'h33);

        // Directed read burst with stalled client
        burst(1'b0, 8'h92, 5'd2, 1'b0, 4, 1'b0);
        check("rd_count", rd_log.size(), 2);
        check("rd_word0", rd_log[0], 32'h46);
        check("rd_word1", rd_log[1], 32'h97);
        check("rd_strobe2", rd_strobes, 2);

        // Address wrap
        wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        burst(1'b1, 8'hFE, 5'd4, 1'b0, 0, 1'b0);
        check("wrap_fe", ram[8'hFE], 32'hA0);
        check("wrap_ff", ram[8'hFF], 32'hA1);
        check("wrap_00", ram[8'h00], 32'hA2);
        check("wrap_01", ram[8'h01], 32'hA3);

        // Illegal lengths; err holds in IDLE, then a legal start clears it
        burst(1'b1, 8'h10, 5'd0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_held", {31'd0, err}, 32'd1);
        burst(1'b0, 8'h20, 5'd17, 1'b0, 0, 1'b0);
        burst(1'b0, 8'h20, 5'd2, 1'b0, 0, 1'b0);

        // Full-length read throughput and ignored start while busy
        burst(1'b0, 8'h40, 5'd16, 1'b0, 0, 1'b0);
        burst(1'b1, 8'h70, 5'd6, 1'b1, 0, 1'b1);
        burst(1'b0, 8'h6E, 5'd5, 1'b1, 0, 1'b1);

        // Reset during the second word of a 5-word write
        exp_waddr.delete(); exp_wdata.delete();
        exp_waddr.push_back(8'h30); exp_wdata.push_back(32'hCAFE0001);
        model_mem[8'h30] = 32'hCAFE0001;
        @(posedge clk); #1;
        done_cnt = 0;
        start = 1'b1; wr = 1'b1; base_addr = 8'h30; len = 5'd5;
        @(posedge clk); #1;
        start = 1'b0; wvalid = 1'b1; wdata = 32'hCAFE0001;
        @(posedge clk); #1;
        wdata = 32'hCAFE0002; clr = 1'b0;
        @(negedge clk);
        check("rstmid_wen", {31'd0, ram_write_enable}, 32'd0);
        check("rstmid_ren", {31'd0, ram_read_enable}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b1; wvalid = 1'b0;
        @(negedge clk);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_wready", {31'd0, wready}, 32'd0);
        check("rstmid_addr", {24'd0, ram_address}, 32'd0);
        check("rstmid_done", done_cnt, 0);
        check("rstmid_left", exp_waddr.size(), 0);
        check("rstmid_w30", ram[8'h30], 32'hCAFE0001);
        check("rstmid_w31", ram[8'h31], model_mem[8'h31]);
        burst(1'b1, 8'h31, 5'd2, 1'b0, 0, 1'b0);

        // Randomized bursts against the model
        for (int n = 0; n < 40; n++)
            burst(1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom_range(0, 18)),
                  1'b1, 0, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
